playfield_scroll_ctrl: RTL and testbench

Sequences the playfield vertical scroll counter chain and holds the horizontal scroll value. CPU scroll writes land in shadow registers. The block then issues a timed VSCRLD load strobe and drives VBD at the next scanline boundary, or at VBLANK entry. It also keeps a reference row count that mirrors the counter chain, for debug and bench checking.

---
 rtl/playfield_pkg.sv | 14 +
 rtl/playfield_scroll_ctrl_shadow.sv | 31 +++
 rtl/playfield_scroll_ctrl.sv | 142 ++++++++++++++
 tb/tb_playfield_scroll_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/playfield_pkg.sv
// Shared types and constants for the playfield scroll controller.
package playfield_pkg;

    typedef logic [8:0] scroll_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } scrl_state_t;

    localparam scroll_t ROW_MASK = 9'h1FF;

endpackage

// File: rtl/playfield_scroll_ctrl_shadow.sv
// Byte-enabled 9-bit scroll shadow register; hit flags any write with an enable set.
module scroll_shadow_reg
    import playfield_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] be,
    input  logic [8:0] data,
    output scroll_t    value,
    output logic       hit
);

    scroll_t value_q;
    scroll_t value_d;

    always_comb begin
        value_d = value_q;
        if (wr_en && be[0]) value_d[7:0] = data[7:0];
        if (wr_en && be[1]) value_d[8]   = data[8];
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;
    assign hit   = wr_en & (|be);

endmodule

// File: rtl/playfield_scroll_ctrl.sv
// Vertical scroll load sequencer and horizontal scroll holder for the playfield.
// Loads are only issued at a scanline boundary or at VBLANK entry.
module playfield_scroll_ctrl
    import playfield_pkg::*;
#(
    parameter int LOAD_HOLD = 2,
    parameter int SCRL_BITS = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr,
    input  logic              cpu_addr,
    input  logic [1:0]        cpu_be,
    input  logic [15:0]       cpu_data,
    input  logic              VBLANK,
    input  logic              HSYNC,
    output logic              VSCRLD,
    output logic [15:0]       VBD,
    output logic [SCRL_BITS-1:0] HSCROLL,
    output logic [SCRL_BITS-1:0] row,
    output logic              pending,
    output scrl_state_t       state
);

    localparam logic [2:0] HOLD_LAST = 3'(LOAD_HOLD - 1);

    scrl_state_t state_q, state_d;
    logic [2:0]  hold_q, hold_d;
    scroll_t     vbd_q, vbd_d;
    scroll_t     hscroll_q, hscroll_d;
    scroll_t     row_q, row_d;
    logic        pending_q, pending_d;
    logic        hsync_q, vblank_q;

    logic        hs_rise, vb_rise;
    logic        vs_hit, hs_hit;
    scroll_t     vs_value, hs_value;
    logic        latch, load_done;
    logic        unused_data;

    assign hs_rise     = HSYNC & ~hsync_q;
    assign vb_rise     = VBLANK & ~vblank_q;
    assign unused_data = ^cpu_data[15:9];

    scroll_shadow_reg u_vs_shadow (
        .clk   (clk),
        .reset (reset),
        .wr_en (cpu_wr & ~cpu_addr),
        .be    (cpu_be),
        .data  (cpu_data[8:0]),
        .value (vs_value),
        .hit   (vs_hit)
    );

    scroll_shadow_reg u_hs_shadow (
        .clk   (clk),
        .reset (reset),
        .wr_en (cpu_wr & cpu_addr),
        .be    (cpu_be),
        .data  (cpu_data[8:0]),
        .value (hs_value),
        .hit   (hs_hit)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = '0;
        latch     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            // A VBLANK rise is itself the qualifying edge, so the resync load
            // latches straight away instead of waiting for the next line.
            IDLE: begin
                if (vb_rise) begin
                    latch   = 1'b1;
                    state_d = LOAD;
                end else if (pending_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hs_rise || vb_rise) begin
                    latch   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (hold_q == HOLD_LAST) begin
                    load_done = 1'b1;
                    state_d   = pending_q ? WAIT : IDLE;
                end else begin
                    hold_d = hold_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vbd_d     = latch ? vs_value : vbd_q;
        hscroll_d = vb_rise ? hs_value : hscroll_q;
        pending_d = pending_q;
        // A write landing on the latch cycle must survive the clear.
        if (latch)  pending_d = 1'b0;
        if (vs_hit) pending_d = 1'b1;
        row_d = row_q;
        if (load_done)
            row_d = vbd_q;
        else if (hs_rise && !VBLANK && state_q != LOAD)
            row_d = (row_q + 9'd1) & ROW_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            vbd_q     <= '0;
            hscroll_q <= '0;
            row_q     <= '0;
            pending_q <= 1'b0;
            hsync_q   <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            vbd_q     <= vbd_d;
            hscroll_q <= hscroll_d;
            row_q     <= row_d;
            pending_q <= pending_d;
            hsync_q   <= HSYNC;
            vblank_q  <= VBLANK;
        end
    end

    assign VSCRLD  = (state_q != LOAD);
    assign VBD     = {7'b0, vbd_q};
    assign HSCROLL = hscroll_q;
    assign row     = row_q;
    assign pending = pending_q;
    assign state   = state_q;

endmodule

// File: tb/tb_playfield_scroll_ctrl.sv
// Directed bench: stimulus pushes expected load values, a negedge monitor checks each VSCRLD pulse.
module tb_playfield_scroll_ctrl;
    import playfield_pkg::*;

    localparam int LOAD_HOLD = 2;

    logic        clk;
    logic        reset;
    logic        cpu_wr;
    logic        cpu_addr;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_data;
    logic        VBLANK;
    logic        HSYNC;
    logic        VSCRLD;
    logic [15:0] VBD;
    logic [8:0]  HSCROLL;
    logic [8:0]  row;
    logic        pending;
    scrl_state_t state;

    playfield_scroll_ctrl #(.LOAD_HOLD(LOAD_HOLD), .SCRL_BITS(9)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_be   (cpu_be),
        .cpu_data (cpu_data),
        .VBLANK   (VBLANK),
        .HSYNC    (HSYNC),
        .VSCRLD   (VSCRLD),
        .VBD      (VBD),
        .HSCROLL  (HSCROLL),
        .row      (row),
        .pending  (pending),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          load_count = 0;
    logic [8:0]  exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: tracks each VSCRLD low pulse and scores it at its trailing edge.
    bit          in_pulse = 0;
    int          plen     = 0;
    logic [15:0] pvbd     = '0;
    bit          pstable  = 1;
    logic [8:0]  exp_v;

    always @(negedge clk) begin
        if (reset) begin
            in_pulse = 0;
        end else if (VSCRLD === 1'b0) begin
            if (!in_pulse) begin
                in_pulse = 1;
                plen     = 1;
                pvbd     = VBD;
                pstable  = 1;
            end else begin
                plen++;
                if (VBD !== pvbd) pstable = 0;
            end
        end else if (in_pulse) begin
            in_pulse = 0;
            load_count++;
            check("load_width", plen, LOAD_HOLD);
            check("vbd_stable", int'(pstable), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_load", int'(pvbd), -1);
            end else begin
                exp_v = exp_q.pop_front();
                check("load_vbd", int'(pvbd), int'({7'b0, exp_v}));
                check("row_after_load", int'(row), int'(exp_v));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic addr, input logic [1:0] be, input logic [15:0] d);
        cpu_wr   = 1'b1;
        cpu_addr = addr;
        cpu_be   = be;
        cpu_data = d;
        tick(1);
        cpu_wr   = 1'b0;
        cpu_be   = 2'b00;
    endtask

    task automatic hsync_pulse();
        HSYNC = 1'b1;
        tick(2);
        HSYNC = 1'b0;
        tick(4);
    endtask

    task automatic vs_load(input logic [1:0] be, input logic [15:0] d, input logic [8:0] exp);
        exp_q.push_back(exp);
        cpu_write(1'b0, be, d);
        tick(2);
        hsync_pulse();
    endtask

    int n;

    initial begin
        reset    = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 1'b0;
        cpu_be   = 2'b00;
        cpu_data = '0;
        VBLANK   = 1'b0;
        HSYNC    = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_vscrld", int'(VSCRLD), 1);
        check("rst_vbd", int'(VBD), 0);
        check("rst_hscroll", int'(HSCROLL), 0);
        check("rst_row", int'(row), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_state", int'(state), int'(IDLE));

        // Mid-frame load with latency probe
        exp_q.push_back(9'h123);
        cpu_write(1'b0, 2'b11, 16'h0123);
        @(negedge clk);
        check("pending_set", int'(pending), 1);
        tick(2);
        HSYNC = 1'b1;
        @(negedge clk);
        check("vscrld_before_edge", int'(VSCRLD), 1);
        tick(1);
        @(negedge clk);
        check("vscrld_latency", int'(VSCRLD), 0);
        check("pending_cleared", int'(pending), 0);
        tick(1);
        HSYNC = 1'b0;
        tick(4);
        @(negedge clk);
        check("row_loaded", int'(row), 9'h123);
        tick(1);
        hsync_pulse();
        @(negedge clk);
        check("row_incr", int'(row), 9'h124);
        tick(1);

        // Row wrap
        vs_load(2'b11, 16'h01FF, 9'h1FF);
        hsync_pulse();
        @(negedge clk);
        check("row_wrap0", int'(row), 9'h000);
        tick(1);
        hsync_pulse();
        @(negedge clk);
        check("row_wrap1", int'(row), 9'h001);
        tick(1);

        // Byte enables
        vs_load(2'b10, 16'h0000, 9'h0FF);
        vs_load(2'b10, 16'h0100, 9'h1FF);
        n = load_count;
        cpu_write(1'b0, 2'b00, 16'h0055);
        @(negedge clk);
        check("be00_no_pending", int'(pending), 0);
        tick(2);
        hsync_pulse();
        @(negedge clk);
        check("be00_no_load", load_count, n);
        tick(1);

        // Horizontal scroll and VBLANK resync
        cpu_write(1'b1, 2'b11, 16'h00A5);
        @(negedge clk);
        check("hs_write_no_pending", int'(pending), 0);
        tick(1);
        hsync_pulse();
        hsync_pulse();
        @(negedge clk);
        check("hscroll_held", int'(HSCROLL), 0);
        tick(1);
        exp_q.push_back(9'h1FF);
        VBLANK = 1'b1;
        @(negedge clk);
        check("hscroll_pre_vb", int'(HSCROLL), 0);
        tick(1);
        @(negedge clk);
        check("hscroll_after_vb", int'(HSCROLL), 9'h0A5);
        tick(4);
        hsync_pulse();
        @(negedge clk);
        check("row_frozen_vblank", int'(row), 9'h1FF);
        tick(1);
        VBLANK = 1'b0;
        tick(2);

        // Write during first LOAD cycle
        exp_q.push_back(9'h033);
        cpu_write(1'b0, 2'b11, 16'h0033);
        tick(2);
        HSYNC = 1'b1;
        tick(1);
        exp_q.push_back(9'h042);
        cpu_write(1'b0, 2'b11, 16'h0042);
        HSYNC = 1'b0;
        tick(2);
        @(negedge clk);
        check("pending_after_load_write", int'(pending), 1);
        tick(1);
        hsync_pulse();
        @(negedge clk);
        check("pending_after_reload", int'(pending), 0);
        check("row_reload", int'(row), 9'h042);
        tick(1);

        // HSYNC and VBLANK rising together give one load
        n = load_count;
        exp_q.push_back(9'h077);
        cpu_write(1'b0, 2'b11, 16'h0077);
        tick(2);
        HSYNC  = 1'b1;
        VBLANK = 1'b1;
        tick(2);
        HSYNC = 1'b0;
        tick(5);
        @(negedge clk);
        check("single_load_hs_vb", load_count, n + 1);
        tick(1);
        VBLANK = 1'b0;
        tick(2);

        // Reset in the first LOAD cycle
        cpu_write(1'b0, 2'b11, 16'h0099);
        tick(2);
        HSYNC = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check("rstload_vscrld", int'(VSCRLD), 1);
        check("rstload_vbd", int'(VBD), 0);
        check("rstload_row", int'(row), 0);
        check("rstload_pending", int'(pending), 0);
        check("rstload_state", int'(state), int'(IDLE));
        tick(1);
        reset = 1'b0;
        HSYNC = 1'b0;
        n = load_count;
        tick(3);
        hsync_pulse();
        hsync_pulse();
        @(negedge clk);
        check("no_pulse_after_reset", load_count, n);
        check("row_after_reset", int'(row), 2);

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
